// File: rtl/ili9341_spi_sink.sv
// ili9341_spi_sink: ILI9341 4-wire SPI receiver, command decoder and pixel tagger; define ILI9341_PIXEL_COUNT_EN to add a saturating pixel_count output
module ili9341_spi_sink #(
   parameter int H_RES      = 240,
   parameter int V_RES      = 240,
   parameter int PIXEL_SIZE = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          spi_sck,
   input  logic                          spi_mosi,
   input  logic                          spi_cs,
   input  logic                          spi_dc,
   output logic [7:0]                    byte_data,
   output logic                          byte_dc,
   output logic                          byte_valid,
   output logic [PIXEL_SIZE-1:0]         pixel_data,
   output logic [$clog2(H_RES)-1:0]      pixel_x,
   output logic [$clog2(V_RES)-1:0]      pixel_y,
   output logic                          pixel_valid,
   output logic                          frame_done,
   output logic                          win_err
`ifdef ILI9341_PIXEL_COUNT_EN
   ,
   output logic [$clog2(H_RES*V_RES+1)-1:0] pixel_count
`endif
);
   localparam int XW = $clog2(H_RES);
   localparam int YW = $clog2(V_RES);

   typedef enum logic [2:0] {CMD, CASET, PASET, RAM_HI, RAM_LO} state_t;

   logic [2:0]    sck_s;
   logic [1:0]    mosi_s, cs_s, dc_s;
   logic          rise;
   logic [7:0]    sr;
   logic [2:0]    bit_cnt;
   logic          done, done_dc;
   state_t        state;
   logic [1:0]    pcnt;
   logic [15:0]   p_start, p_end;
   logic [7:0]    p_eh, hi;
   logic          win_ok;
   logic [XW-1:0] xs, xe, cx;
   logic [YW-1:0] ys, ye, cy;

   assign rise = sck_s[1] & ~sck_s[2];

   // two-stage synchronisers, plus a third sck stage for rising-edge detection
   always_ff @(posedge clk)
      if (rst) begin
         sck_s  <= '0;
         mosi_s <= '0;
         cs_s   <= '0;
         dc_s   <= '0;
      end else begin
         sck_s  <= {sck_s[1:0], spi_sck};
         mosi_s <= {mosi_s[0], spi_mosi};
         cs_s   <= {cs_s[0], spi_cs};
         dc_s   <= {dc_s[0], spi_dc};
      end

   // MSB-first deserializer; cs release drops any partial byte
   always_ff @(posedge clk)
      if (rst) begin
         sr      <= '0;
         bit_cnt <= '0;
         done    <= 1'b0;
         done_dc <= 1'b0;
      end else begin
         done <= 1'b0;
         if (cs_s[1])
            bit_cnt <= '0;
         else if (rise) begin
            sr      <= {sr[6:0], mosi_s[1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               done    <= 1'b1;
               done_dc <= dc_s[1];
            end
         end
      end

   // registered byte output stage
   always_ff @(posedge clk)
      if (rst) begin
         byte_data  <= '0;
         byte_dc    <= 1'b0;
         byte_valid <= 1'b0;
      end else begin
         byte_valid <= done;
         if (done) begin
            byte_data <= sr;
            byte_dc   <= done_dc;
         end
      end

   // window commit check on the final CASET/PASET parameter byte
   always_comb begin
      p_end  = {p_eh, byte_data};
      win_ok = (p_start <= p_end) && (p_end < ((state == CASET) ? 16'(H_RES) : 16'(V_RES)));
   end

   // command decoder, window registers and pixel cursor
   always_ff @(posedge clk)
      if (rst) begin
         state       <= CMD;
         pcnt        <= '0;
         p_start     <= '0;
         p_eh        <= '0;
         hi          <= '0;
         xs          <= '0;
         xe          <= XW'(H_RES - 1);
         ys          <= '0;
         ye          <= YW'(V_RES - 1);
         cx          <= '0;
         cy          <= '0;
         pixel_valid <= 1'b0;
         pixel_data  <= '0;
         pixel_x     <= '0;
         pixel_y     <= '0;
         frame_done  <= 1'b0;
         win_err     <= 1'b0;
      end else begin
         pixel_valid <= 1'b0;
         frame_done  <= 1'b0;
         win_err     <= 1'b0;
         if (byte_valid && !byte_dc) begin
            pcnt  <= '0;
            state <= CMD;
            if (byte_data == 8'h2A)
               state <= CASET;
            else if (byte_data == 8'h2B)
               state <= PASET;
            else if (byte_data == 8'h2C) begin
               state <= RAM_HI;
               cx    <= xs;
               cy    <= ys;
            end else if (byte_data == 8'h01) begin
               xs <= '0;
               xe <= XW'(H_RES - 1);
               ys <= '0;
               ye <= YW'(V_RES - 1);
            end
         end else if (byte_valid) begin
            if (state == CASET || state == PASET) begin
               pcnt <= pcnt + 2'd1;
               if (pcnt == 2'd0) p_start[15:8] <= byte_data;
               if (pcnt == 2'd1) p_start[7:0] <= byte_data;
               if (pcnt == 2'd2) p_eh <= byte_data;
               if (pcnt == 2'd3) begin
                  state <= CMD;
                  if (!win_ok)
                     win_err <= 1'b1;
                  else if (state == CASET) begin
                     xs <= XW'(p_start);
                     xe <= XW'(p_end);
                  end else begin
                     ys <= YW'(p_start);
                     ye <= YW'(p_end);
                  end
               end
            end
            if (state == RAM_HI) begin
               hi    <= byte_data;
               state <= RAM_LO;
            end
            if (state == RAM_LO) begin
               pixel_valid <= 1'b1;
               pixel_data  <= PIXEL_SIZE'({hi, byte_data});
               pixel_x     <= cx;
               pixel_y     <= cy;
               state       <= RAM_HI;
               if (cx == xe) begin
                  cx <= xs;
                  if (cy == ye) begin
                     frame_done <= 1'b1;
                     cy         <= ys;
                  end else
                     cy <= cy + YW'(1);
               end else
                  cx <= cx + XW'(1);
            end
         end else if (cs_s[1] && state == RAM_LO)
            state <= RAM_HI;
      end

`ifdef ILI9341_PIXEL_COUNT_EN
   localparam int CW = $clog2(H_RES*V_RES+1);
   localparam logic [CW-1:0] PIX_MAX = CW'(H_RES*V_RES);

   // pixel counter, cleared by RAMWR and saturating at a full panel
   always_ff @(posedge clk)
      if (rst || (byte_valid && !byte_dc && byte_data == 8'h2C))
         pixel_count <= '0;
      else if (pixel_valid && pixel_count != PIX_MAX)
         pixel_count <= pixel_count + CW'(1);
`endif

endmodule

// File: tb/tb_ili9341_spi_sink.sv
// tb_ili9341_spi_sink: table-driven and randomized self-checking bench for ili9341_spi_sink
module tb_ili9341_spi_sink;
   logic clk = 1'b0;
   logic rst, spi_sck, spi_mosi, spi_cs, spi_dc;
   logic [7:0] byte_data;
   logic byte_dc, byte_valid, pixel_valid, frame_done, win_err;
   logic [15:0] pixel_data;
   logic [7:0] pixel_x, pixel_y;
`ifdef ILI9341_PIXEL_COUNT_EN
   logic [15:0] pixel_count;
`endif

   ili9341_spi_sink dut (
      .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_cs(spi_cs), .spi_dc(spi_dc),
      .byte_data(byte_data), .byte_dc(byte_dc), .byte_valid(byte_valid),
      .pixel_data(pixel_data), .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
      .frame_done(frame_done), .win_err(win_err)
`ifdef ILI9341_PIXEL_COUNT_EN
      , .pixel_count(pixel_count)
`endif
   );

   always #5 clk = ~clk;

   int tests = 0, fails = 0;
   int werr = 0, orphan = 0, exp_werr = 0;
   int mxs = 0, mxe = 239, mys = 0, mye = 239, n = 0;
   logic [32:0] pq[$];
   logic [32:0] eq[$];
   logic [8:0]  bq[$];

   typedef struct {
      logic [7:0]  c;
      logic [15:0] s, e;
      logic        err;
      logic [7:0]  px, py;
   } wrow_t;
   wrow_t tbl[9];

   // output monitor: collects pixel/byte events and counts strobes
   always @(negedge clk)
      if (!rst) begin
         if (pixel_valid) pq.push_back({frame_done, pixel_y, pixel_x, pixel_data});
         if (byte_valid) bq.push_back({byte_dc, byte_data});
         if (win_err) werr++;
         if (frame_done && !pixel_valid) orphan++;
      end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic d);
      for (int i = 7; i >= 0; i--) begin
         spi_sck = 1'b0; spi_mosi = b[i]; spi_dc = d;
         tick(2);
         spi_sck = 1'b1;
         tick(2);
      end
      spi_sck = 1'b0;
   endtask

   task automatic cs_toggle();
      spi_cs = 1'b1;
      tick(4);
      spi_cs = 1'b0;
      tick(2);
   endtask

   function automatic void model_cmd(input logic [7:0] b);
      if (b == 8'h2C) n = 0;
      if (b == 8'h01) begin mxs = 0; mxe = 239; mys = 0; mye = 239; end
   endfunction

   function automatic void model_pix(input logic [15:0] d);
      int w, h, x, y;
      logic fd;
      w = mxe - mxs + 1;
      h = mye - mys + 1;
      x = mxs + n % w;
      y = mys + (n / w) % h;
      fd = (n % (w * h)) == w * h - 1;
      eq.push_back({fd, 8'(y), 8'(x), d});
      n++;
   endfunction

   task automatic cmd(input logic [7:0] b);
      send_byte(b, 1'b0);
      model_cmd(b);
   endtask

   task automatic win(input logic [7:0] c, input logic [15:0] s, input logic [15:0] e);
      cmd(c);
      send_byte(s[15:8], 1'b1); send_byte(s[7:0], 1'b1);
      send_byte(e[15:8], 1'b1); send_byte(e[7:0], 1'b1);
      if (s > e || e >= 16'd240) exp_werr++;
      else if (c == 8'h2A) begin mxs = int'(s); mxe = int'(e); end
      else begin mys = int'(s); mye = int'(e); end
   endtask

   task automatic pix(input logic [15:0] d);
      send_byte(d[15:8], 1'b1);
      send_byte(d[7:0], 1'b1);
      model_pix(d);
   endtask

   task automatic check_pixels(input string nm);
      tick(8);
      chk({nm, " count"}, 64'(pq.size()), 64'(eq.size()));
      for (int i = 0; i < eq.size() && i < pq.size(); i++) chk(nm, pq[i], eq[i]);
      pq.delete();
      eq.delete();
   endtask

   initial begin
      logic [7:0] v;
      logic [32:0] got;
      int w0, xs, xe, ys, ye, np;

      tbl[0] = '{8'h2A, 16'd10,  16'd11,  1'b0, 8'd10,  8'd0};
      tbl[1] = '{8'h2A, 16'd240, 16'd245, 1'b1, 8'd0,   8'd0};
      tbl[2] = '{8'h2A, 16'd5,   16'd4,   1'b1, 8'd0,   8'd0};
      tbl[3] = '{8'h2A, 16'd239, 16'd239, 1'b0, 8'd239, 8'd0};
      tbl[4] = '{8'h2B, 16'd5,   16'd6,   1'b0, 8'd0,   8'd5};
      tbl[5] = '{8'h2B, 16'd0,   16'd240, 1'b1, 8'd0,   8'd0};
      tbl[6] = '{8'h2B, 16'd200, 16'd239, 1'b0, 8'd0,   8'd200};
      tbl[7] = '{8'h2A, 16'd256, 16'd257, 1'b1, 8'd0,   8'd0};
      tbl[8] = '{8'h2B, 16'd0,   16'd0,   1'b0, 8'd0,   8'd0};

      rst = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0; spi_cs = 1'b1; spi_dc = 1'b0;
      tick(3);
      chk("reset outputs", {byte_data, byte_dc, byte_valid, pixel_data, pixel_x, pixel_y,
                            pixel_valid, frame_done, win_err}, 64'd0);
`ifdef ILI9341_PIXEL_COUNT_EN
      chk("reset pixel_count", pixel_count, 0);
`endif
      rst = 1'b0; spi_cs = 1'b0;
      tick(2);

      // RAMWR command byte with exact strobe latency after the 8th sck edge
      v = 8'h2C;
      for (int i = 7; i >= 0; i--) begin
         spi_sck = 1'b0; spi_mosi = v[i]; spi_dc = 1'b0;
         tick(2);
         spi_sck = 1'b1;
         if (i > 0) tick(2);
      end
      tick(3);
      chk("byte_valid early", byte_valid, 0);
      tick(1);
      chk("byte strobe", {byte_valid, byte_dc, byte_data}, {1'b1, 1'b0, 8'h2C});
      tick(1);
      chk("byte_valid width", byte_valid, 0);
      spi_sck = 1'b0;
      model_cmd(8'h2C);
      pix(16'hABCD);
      check_pixels("first pixel after RAMWR");

      // partial byte dropped by cs release
      cmd(8'h00);
      tick(8);
      bq.delete();
      for (int i = 0; i < 5; i++) begin
         spi_sck = 1'b0; spi_mosi = 1'b1; spi_dc = 1'b1;
         tick(2);
         spi_sck = 1'b1;
         tick(2);
      end
      spi_sck = 1'b0;
      cs_toggle();
      send_byte(8'hA5, 1'b1);
      tick(8);
      chk("fragment byte count", 64'(bq.size()), 1);
      chk("fragment byte", bq.size() > 0 ? bq[0] : 9'h0, {1'b1, 8'hA5});
      bq.delete();

      // window commit table
      foreach (tbl[r]) begin
         cmd(8'h01);
         tick(8);
         w0 = werr;
         win(tbl[r].c, tbl[r].s, tbl[r].e);
         tick(8);
         chk("row win_err", 64'(werr - w0), 64'(tbl[r].err));
         cmd(8'h2C);
         pix(16'(r));
         tick(8);
         chk("row pixel count", 64'(pq.size()), 1);
         got = pq.size() > 0 ? pq[0] : '1;
         chk("row first pixel xy", got[31:16], {tbl[r].py, tbl[r].px});
         pq.delete();
         eq.delete();
      end

      // 2x2 window frame wrap
      win(8'h2A, 16'd10, 16'd11);
      win(8'h2B, 16'd5, 16'd6);
      cmd(8'h2C);
      pix(16'hF800); pix(16'h07E0); pix(16'h001F); pix(16'hFFFF); pix(16'h1234);
      check_pixels("2x2 frame");

      // incomplete CASET leaves the window alone
      cmd(8'h01);
      cmd(8'h2A);
      send_byte(8'h00, 1'b1); send_byte(8'h05, 1'b1);
      cmd(8'h2C);
      pix(16'h5555);
      check_pixels("partial caset");

      // pending high byte dropped by cs release in RAM_LO
      send_byte(8'h12, 1'b1);
      tick(2);
      cs_toggle();
      pix(16'h3456);
      check_pixels("cs drop high byte");

      // default window row wrap
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      model_cmd(8'h01);
      tick(2);
      cmd(8'h2C);
      for (int i = 0; i < 242; i++) pix(16'(i * 7));
      check_pixels("default row wrap");
`ifdef ILI9341_PIXEL_COUNT_EN
      chk("pixel_count", pixel_count, 242);
`endif

      // randomized windows and pixel streams against the model
      for (int it = 0; it < 8; it++) begin
         xs = $urandom_range(0, 239); xe = xs + $urandom_range(0, 3);
         ys = $urandom_range(0, 239); ye = ys + $urandom_range(0, 3);
         if ($urandom_range(0, 4) == 0) xe = xs - 1;
         win(8'h2A, 16'(xs), 16'(xe));
         win(8'h2B, 16'(ys), 16'(ye));
         cmd(8'h2C);
         np = $urandom_range(1, 20);
         for (int k = 0; k < np; k++) begin
            if ($urandom_range(0, 5) == 0) begin
               send_byte(8'($urandom), 1'b1);
               tick(2);
               cs_toggle();
            end
            pix(16'($urandom));
         end
         check_pixels("random stream");
      end

      // reset in the middle of a pixel at (100,50)
      win(8'h2A, 16'd100, 16'd101);
      win(8'h2B, 16'd50, 16'd51);
      cmd(8'h2C);
      send_byte(8'hBE, 1'b1);
      send_byte(8'hEF, 1'b1);
      tick(2);
      chk("pre-reset byte_valid", byte_valid, 1);
      rst = 1'b1;
      tick(1);
      chk("mid-frame reset outputs", {byte_data, byte_dc, byte_valid, pixel_data, pixel_x, pixel_y,
                                      pixel_valid, frame_done, win_err}, 64'd0);
      rst = 1'b0;
      model_cmd(8'h01);
      tick(2);
      cmd(8'h2C);
      pix(16'h1234);
      check_pixels("after reset");
`ifdef ILI9341_PIXEL_COUNT_EN
      chk("pixel_count after reset", pixel_count, 1);
`endif

      chk("win_err total", 64'(werr), 64'(exp_werr));
      chk("orphan frame_done", 64'(orphan), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
